// File: rtl/multi_channel_credit_shell.sv
// Per-destination credit regulator for a NoC master.
// Gates sends on the destination's credits, returns credits on replies, and supports a drain/quiesce handshake.
module multi_channel_credit_shell #(
  parameter int NUM_CHANNELS = 4,
  parameter int NUM_CREDITS  = 8,
  localparam int DW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
  localparam int CW = $clog2(NUM_CREDITS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       send_valid,
  input  logic [DW-1:0]              send_dest,
  output logic                       send_ready,
  output logic                       noc_valid,
  input  logic                       noc_ready,
  input  logic                       resp_valid,
  input  logic [DW-1:0]              resp_src,
  input  logic                       resp_ready,
  input  logic                       drain_req,
  output logic                       drained,
  output logic [NUM_CHANNELS*CW-1:0] credits,
  output logic                       err_overflow,
  output logic                       err_bad_dest
);

  localparam logic [DW:0]   NCH  = (DW + 1)'(NUM_CHANNELS);
  localparam logic [CW-1:0] FULL = CW'(NUM_CREDITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {ACTIVE, DRAINING, DRAINED} state_t;

  state_t                  state;
  logic [CW-1:0]           cnt [NUM_CHANNELS];
  logic                    send_dest_ok;
  logic                    resp_src_ok;
  logic                    sel_nonzero;
  logic                    all_full;
  logic                    has_credit;
  logic [NUM_CHANNELS-1:0] send_fire;
  logic [NUM_CHANNELS-1:0] resp_fire;
  logic [NUM_CHANNELS-1:0] overflow_hit;

  // Zero-extend the index so the range check also works when NUM_CHANNELS is a power of two.
  assign send_dest_ok = ({1'b0, send_dest} < NCH);
  assign resp_src_ok  = ({1'b0, resp_src} < NCH);

  always_comb begin
    sel_nonzero = 1'b0;
    all_full    = 1'b1;
    credits     = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (send_dest == DW'(i) && cnt[i] != '0) sel_nonzero = 1'b1;
      if (cnt[i] != FULL) all_full = 1'b0;
      credits[i*CW +: CW] = cnt[i];
    end
  end

  assign has_credit = send_dest_ok && sel_nonzero && (state == ACTIVE);
  assign noc_valid  = send_valid && has_credit;
  assign send_ready = has_credit && noc_ready;

  always_comb begin
    send_fire    = '0;
    resp_fire    = '0;
    overflow_hit = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      send_fire[i]    = send_valid && send_ready && (send_dest == DW'(i));
      resp_fire[i]    = resp_valid && resp_ready && resp_src_ok && (resp_src == DW'(i));
      overflow_hit[i] = resp_fire[i] && !send_fire[i] && (cnt[i] == FULL);
    end
  end

  // A same-channel send and reply cancel out; an overflowing reply saturates at FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) cnt[i] <= FULL;
      err_overflow <= 1'b0;
      err_bad_dest <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (send_fire[i] && !resp_fire[i])
          cnt[i] <= cnt[i] - ONE;
        else if (resp_fire[i] && !send_fire[i] && cnt[i] != FULL)
          cnt[i] <= cnt[i] + ONE;
      end
      if (|overflow_hit) err_overflow <= 1'b1;
      if ((send_valid && !send_dest_ok) || (resp_valid && !resp_src_ok))
        err_bad_dest <= 1'b1;
    end
  end

  // Drain FSM; drained is registered alongside the state so it lags the entry into DRAINING.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACTIVE;
      drained <= 1'b0;
    end else begin
      case (state)
        ACTIVE: begin
          if (drain_req) state <= DRAINING;
        end
        DRAINING: begin
          if (!drain_req) begin
            state <= ACTIVE;
          end else if (all_full) begin
            state   <= DRAINED;
            drained <= 1'b1;
          end
        end
        DRAINED: begin
          if (!drain_req) begin
            state   <= ACTIVE;
            drained <= 1'b0;
          end
        end
        default: begin
          state   <= ACTIVE;
          drained <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_channel_credit_shell.sv
// Directed self-checking bench for multi_channel_credit_shell.
// A second instance with three channels exercises out-of-range indices.
module tb_multi_channel_credit_shell;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_valid = 1'b0;
  logic [1:0]  send_dest = '0;
  logic        send_ready;
  logic        noc_valid;
  logic        noc_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [1:0]  resp_src = '0;
  logic        resp_ready = 1'b0;
  logic        drain_req = 1'b0;
  logic        drained;
  logic [15:0] credits;
  logic        err_overflow;
  logic        err_bad_dest;

  logic        b_send_valid = 1'b0;
  logic [1:0]  b_send_dest = '0;
  logic        b_send_ready;
  logic        b_noc_valid;
  logic        b_resp_valid = 1'b0;
  logic [1:0]  b_resp_src = '0;
  logic        b_drained;
  logic [5:0]  b_credits;
  logic        b_err_overflow;
  logic        b_err_bad_dest;

  int checks = 0;
  int errors = 0;

  multi_channel_credit_shell #(.NUM_CHANNELS(4), .NUM_CREDITS(8)) u_dut (
    .clk(clk), .rst(rst),
    .send_valid(send_valid), .send_dest(send_dest), .send_ready(send_ready),
    .noc_valid(noc_valid), .noc_ready(noc_ready),
    .resp_valid(resp_valid), .resp_src(resp_src), .resp_ready(resp_ready),
    .drain_req(drain_req), .drained(drained), .credits(credits),
    .err_overflow(err_overflow), .err_bad_dest(err_bad_dest)
  );

  multi_channel_credit_shell #(.NUM_CHANNELS(3), .NUM_CREDITS(2)) u_bad (
    .clk(clk), .rst(rst),
    .send_valid(b_send_valid), .send_dest(b_send_dest), .send_ready(b_send_ready),
    .noc_valid(b_noc_valid), .noc_ready(1'b1),
    .resp_valid(b_resp_valid), .resp_src(b_resp_src), .resp_ready(1'b1),
    .drain_req(1'b0), .drained(b_drained), .credits(b_credits),
    .err_overflow(b_err_overflow), .err_bad_dest(b_err_bad_dest)
  );

  always #5 clk = ~clk;

  function automatic int cr(input int i);
    return int'(credits[i*CW +: CW]);
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change one time unit after the rising edge and settle before checks.
  task automatic applyStimulus(input logic sv, input logic [1:0] sd, input logic rv,
                               input logic [1:0] rs, input logic nr, input logic dr);
    send_valid = sv;
    send_dest  = sd;
    resp_valid = rv;
    resp_ready = rv;
    resp_src   = rs;
    noc_ready  = nr;
    drain_req  = dr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) checkOutput($sformatf("reset_credit%0d", i), cr(i), 8);
    checkOutput("reset_drained", drained, 0);
    checkOutput("reset_err_overflow", err_overflow, 0);
    checkOutput("reset_err_bad_dest", err_bad_dest, 0);
    checkOutput("reset_noc_valid", noc_valid, 0);
    rst = 1'b0;
    tick();

    // Eight back-to-back sends to destination 2.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 2, 0, 0, 1, 0);
      checkOutput($sformatf("burst_ready%0d", k), send_ready, 1);
      checkOutput($sformatf("burst_credit2_%0d", k), cr(2), 8 - k);
      tick();
    end
    applyStimulus(1, 2, 0, 0, 1, 0);
    checkOutput("burst_empty_credit2", cr(2), 0);
    checkOutput("burst_empty_ready", send_ready, 0);
    checkOutput("burst_empty_noc_valid", noc_valid, 0);
    checkOutput("burst_other_credit0", cr(0), 8);
    checkOutput("burst_other_credit3", cr(3), 8);
    tick();

    // Empty channel 1, then send and reply together.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 1, 0, 0, 1, 0);
      tick();
    end
    applyStimulus(1, 1, 1, 1, 1, 0);
    checkOutput("bypass_credit1_0", cr(1), 0);
    checkOutput("bypass_no_accept", send_ready, 0);
    tick();
    applyStimulus(1, 1, 0, 0, 1, 0);
    checkOutput("bypass_credit1_1", cr(1), 1);
    checkOutput("bypass_accept_next", send_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("bypass_credit1_back0", cr(1), 0);

    // Channel 3 down to 5, then simultaneous same- and cross-channel fires.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 3, 0, 0, 1, 0);
      tick();
    end
    applyStimulus(1, 3, 1, 3, 1, 0);
    checkOutput("same_ch_pre_credit3", cr(3), 5);
    tick();
    applyStimulus(1, 0, 1, 3, 1, 0);
    checkOutput("same_ch_credit3", cr(3), 5);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("cross_ch_credit0", cr(0), 7);
    checkOutput("cross_ch_credit3", cr(3), 6);

    // Overflow on channel 0.
    applyStimulus(0, 0, 1, 0, 1, 0);
    tick();
    checkOutput("ovf_refill_credit0", cr(0), 8);
    checkOutput("ovf_not_yet", err_overflow, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("ovf_credit0_sat", cr(0), 8);
    checkOutput("ovf_flag", err_overflow, 1);
    tick();
    checkOutput("ovf_sticky", err_overflow, 1);

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_credit2", cr(2), 8);
    checkOutput("async_rst_credit1", cr(1), 8);
    checkOutput("async_rst_err_overflow", err_overflow, 0);
    tick();
    rst = 1'b0;
    tick();

    // Three outstanding on channel 0, then drain.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 0, 0, 0, 1, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("drain_req_cycle_ready", send_ready, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 1, 1);
    checkOutput("draining_ready", send_ready, 0);
    checkOutput("draining_noc_valid", noc_valid, 0);
    checkOutput("draining_credit0", cr(0), 5);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 1, 0, 1, 1);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("drain_credit0_full", cr(0), 8);
    checkOutput("drain_not_yet", drained, 0);
    tick();
    checkOutput("drained_set", drained, 1);
    applyStimulus(1, 1, 0, 0, 1, 0);
    checkOutput("drained_ready", send_ready, 0);
    tick();
    checkOutput("resume_drained", drained, 0);
    checkOutput("resume_ready", send_ready, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 0);
    checkOutput("resume_credit1", cr(1), 7);

    // Out-of-range destination on the three-channel instance.
    b_send_valid = 1'b1;
    b_send_dest  = 2'd3;
    #1;
    checkOutput("bad_dest_ready", b_send_ready, 0);
    checkOutput("bad_dest_noc_valid", b_noc_valid, 0);
    checkOutput("bad_dest_before", b_err_bad_dest, 0);
    tick();
    b_send_valid = 1'b0;
    #1;
    checkOutput("bad_dest_flag", b_err_bad_dest, 1);
    checkOutput("bad_dest_credits", int'(b_credits), 42);
    b_send_valid = 1'b1;
    b_send_dest  = 2'd2;
    #1;
    checkOutput("good_dest_ready", b_send_ready, 1);
    tick();
    b_send_valid = 1'b0;
    #1;
    checkOutput("good_dest_credits", int'(b_credits), 26);
    checkOutput("bad_dest_sticky", b_err_bad_dest, 1);
    checkOutput("main_no_bad_dest", err_bad_dest, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
